// File: rtl/encoder_8_3_seq_pkg.sv
// Shared constants, FSM state type and one-hot helper for the sequential 8-to-3 encoder.
package encoder_8_3_seq_pkg;

   localparam int unsigned N_IN   = 8;
   localparam int unsigned CODE_W = $clog2(N_IN);

   typedef enum logic [0:0] {
      StIdle    = 1'b0,
      StPresent = 1'b1
   } enc_state_e;

   function automatic logic [N_IN-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
      logic [N_IN-1:0] one;
      one = {{(N_IN-1){1'b0}}, 1'b1};
      return one << code;
   endfunction

endpackage

// File: rtl/encoder_8_3_seq_pri_enc.sv
// Combinational 8-to-3 priority encoder; idx_o is 0 when no bit is set.
module encoder_8_3_seq_pri_enc
   import encoder_8_3_seq_pkg::*;
#(
   parameter bit MSB_PRIO = 1'b1
) (
   input  logic [N_IN-1:0]   vec_i,
   output logic [CODE_W-1:0] idx_o,
   output logic              any_o
);

   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      // Scan towards the highest-priority end so the last hit wins.
      if (MSB_PRIO) begin
         for (int i = 0; i < int'(N_IN); i++) begin
            if (vec_i[i]) idx_o = CODE_W'(i);
         end
      end else begin
         for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = CODE_W'(i);
         end
      end
   end

endmodule

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 priority encoder: latches requests into pend and drains one code per
// accepted valid/ready transfer, highest priority first.
module encoder_8_3_seq
   import encoder_8_3_seq_pkg::*;
#(
   parameter bit MSB_PRIO = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              e_i,
   input  logic [N_IN-1:0]   d_i,
   output logic [CODE_W-1:0] y_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [N_IN-1:0]   pend_o,
   output logic              idle_o
);

   logic [N_IN-1:0]   pend_q, pend_d;
   logic [CODE_W-1:0] y_q, y_d;
   logic              valid_q, valid_d;
   enc_state_e        state_q, state_d;

   logic [CODE_W-1:0] pri_idx;
   logic              pri_any;
   logic              slot_free;
   logic [N_IN-1:0]   take_mask;

   encoder_8_3_seq_pri_enc #(
      .MSB_PRIO (MSB_PRIO)
   ) u_pri_enc (
      .vec_i (pend_q),
      .idx_o (pri_idx),
      .any_o (pri_any)
   );

   always_comb begin
      slot_free = !valid_q || ready_i;
      take_mask = '0;
      valid_d   = valid_q;
      y_d       = y_q;
      state_d   = state_q;

      if (slot_free) begin
         valid_d = pri_any;
         if (pri_any) begin
            y_d       = pri_idx;
            take_mask = code_to_onehot(pri_idx);
         end
      end

      // New requests are ORed in after the take, so a colliding set re-pends the bit.
      pend_d = (pend_q & ~take_mask) | (e_i ? d_i : '0);

      case (state_q)
         StIdle: begin
            if (slot_free && pri_any) state_d = StPresent;
         end
         StPresent: begin
            if (ready_i && !pri_any) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q  <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         state_q <= StIdle;
      end else begin
         pend_q  <= pend_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         state_q <= state_d;
      end
   end

   assign y_o     = y_q;
   assign valid_o = valid_q;
   assign pend_o  = pend_q;
   assign idle_o  = (pend_q == '0) && !valid_q;

endmodule
